seq_pattern_gen: RTL
====================

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameter: PAT_W, 8, maximum pattern length in bits (2..16).
REQ-002 Parameter: LEN_W, 4, width of len input; SHALL satisfy 2**LEN_W >= PAT_W.
REQ-003 Parameter: REP_W, 4, width of rep input.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to transmit; sampled only in IDLE.
REQ-007 pattern  input  PAT_W  bits to transmit; captured on accepted start.
REQ-008 len  input  LEN_W  pattern length; 0 means PAT_W.
REQ-009 rep  input  REP_W  extra repetitions; total passes = rep+1.
REQ-010 abort  input  1  synchronous cancel of an active transfer.
REQ-011 ready  input  1  downstream accepts out_bit when out_valid and ready are both high.
REQ-012 out_bit  output  1  current serial bit.
REQ-013 out_valid  output  1  out_bit is valid.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the final bit is accepted.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT, GAP and DONE; GAP is reachable only when the macro in REQ-030 is defined.
REQ-017 IDLE + start=1 -> capture pattern, len and rep; set bit index = effective_len-1; next state SHIFT. start=0 -> stay in IDLE.
REQ-018 Bits SHALL be sent MSB-first within the effective_len-bit window: pattern[effective_len-1] down to pattern[0]. pattern=4'b1011 emits 1,0,1,1.
REQ-019 First out_valid SHALL be high in the cycle after the edge that accepted start; latency is 1 cycle.
REQ-020 In SHIFT, out_valid=1 and out_bit=captured bit at the current index; both held stable while ready=0.
REQ-021 Index advances only on out_valid&ready; index 0 accepted -> the pass ends.
REQ-022 Pass end with remaining repetitions > 0 -> decrement the repetition count, reload index = effective_len-1, continue in SHIFT, no idle cycle (macro undefined).
REQ-023 Pass end with remaining repetitions = 0 -> DONE; in DONE, done=1 and out_valid=0 for exactly one cycle, then IDLE.
REQ-024 start while busy=1 SHALL be ignored. Changes to pattern, len or rep after capture SHALL NOT affect the transfer.
REQ-025 abort=1 in SHIFT or GAP -> IDLE at the next edge; no done pulse. abort has priority over ready on the same edge. abort in IDLE or DONE has no effect.
REQ-026 In IDLE, out_bit=0 and out_valid=0. In DONE, out_bit=0.
REQ-027 len greater than PAT_W SHALL be clamped to PAT_W.

Reset
REQ-028 reset low SHALL force IDLE immediately, without waiting for clk: out_bit=0, out_valid=0, busy=0, done=0, and all counters and captured registers cleared.
REQ-029 Reset asserted mid-transfer SHALL discard the transfer. The first start accepted after reset release SHALL begin a fresh transfer.

Configuration
REQ-030 Macro SEQ_PATTERN_GEN_GAP_EN:
  - Defined: between consecutive passes the FSM enters GAP for one cycle (out_valid=0, busy=1), then returns to SHIFT.
  - Undefined: GAP state and its logic are not compiled; passes are back-to-back per REQ-022.

Verification
REQ-031 pattern=8'h0B, len=4, rep=0, ready=1, start pulse -> out_bit 1,0,1,1 on 4 consecutive valid cycles; done high in the following cycle; busy low after that.
REQ-032 Same as REQ-031 with ready=0 for 3 cycles while bit index 2 is presented -> out_bit=0 and out_valid=1 held for 4 cycles; total sequence unchanged.
REQ-033 pattern=4'b1011, len=4, rep=2, ready=1 -> 12 bits 101110111011 with no gap; with SEQ_PATTERN_GEN_GAP_EN defined, one out_valid=0 cycle after bits 4 and 8; single done pulse.
REQ-034 len=0, pattern=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1; len=9 produces the same result.
REQ-035 abort at the 2nd bit -> out_valid=0 and busy=0 from the next cycle; no done pulse; a new start is accepted immediately afterwards.
REQ-036 reset driven low between clock edges during SHIFT -> out_valid, busy and done go to 0 before the next edge; start after release produces the full sequence.

Source files
------------

// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: request/serial-output bundle for seq_pattern_gen.
// master = requester (drives start/pattern/len/rep/abort/ready),
// slave  = the pattern generator.
interface seq_pattern_gen_if #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int REP_W = 4
);
   logic             start;
   logic [PAT_W-1:0] pattern;
   logic [LEN_W-1:0] len;
   logic [REP_W-1:0] rep;
   logic             abort;
   logic             ready;
   logic             out_bit;
   logic             out_valid;
   logic             busy;
   logic             done;

   modport master (
      output start, pattern, len, rep, abort, ready,
      input  out_bit, out_valid, busy, done
   );

   modport slave (
      input  start, pattern, len, rep, abort, ready,
      output out_bit, out_valid, busy, done
   );
endinterface

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serialises a captured pattern MSB-first, (rep+1) passes,
// with a valid/ready handshake on the serial output.
// Optional feature macro: SEQ_PATTERN_GEN_GAP_EN inserts a one-cycle idle
// gap (busy high, out_valid low) between consecutive passes.
//
// state | meaning
// IDLE  | waiting for start; outputs low
// SHIFT | presenting pat_q[idx_q]; advances on out_valid & ready
// GAP   | one dead cycle between passes (only with SEQ_PATTERN_GEN_GAP_EN)
// DONE  | one-cycle done pulse, then back to IDLE
module seq_pattern_gen #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int REP_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   seq_pattern_gen_if.slave  bus
);
   localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
`ifdef SEQ_PATTERN_GEN_GAP_EN
      S_GAP   = 2'd2,
`endif
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [IDX_W-1:0] eff_last;

   // Highest bit index of the window; len of 0 or above PAT_W means full width.
   always_comb begin
      if (bus.len == '0 || {1'b0, bus.len} > (LEN_W+1)'(PAT_W))
         eff_last = IDX_W'(PAT_W - 1);
      else
         eff_last = IDX_W'(bus.len - 1'b1);
   end

   // State and capture registers; reset drops everything back to IDLE at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         last_q  <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
      end
   end

   // Next-state logic; abort outranks the handshake in active states.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      last_d  = last_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               pat_d   = bus.pattern;
               last_d  = eff_last;
               idx_d   = eff_last;
               rep_d   = bus.rep;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (bus.ready) begin
               if (idx_q != '0) begin
                  idx_d = idx_q - 1'b1;
               end else if (rep_q != '0) begin
                  rep_d = rep_q - 1'b1;
                  idx_d = last_q;
`ifdef SEQ_PATTERN_GEN_GAP_EN
                  state_d = S_GAP;
`else
                  state_d = S_SHIFT;
`endif
               end else begin
                  state_d = S_DONE;
               end
            end
         end
`ifdef SEQ_PATTERN_GEN_GAP_EN
         S_GAP: begin
            if (bus.abort)
               state_d = S_IDLE;
            else
               state_d = S_SHIFT;
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.out_valid = (state_q == S_SHIFT);
   assign bus.out_bit   = (state_q == S_SHIFT) & pat_q[idx_q];
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);

endmodule
